// File: rtl/formula_sweep_pkg.sv
// Shared definitions for the formula sweep driver.
// Holds the controller state encoding and the default formula input width.
// Imported by formula_sweep_driver and masked_inc.
package formula_sweep_pkg;

    // Default width of the formula input vector.
    localparam int NUM_IN_DEF = 25;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/masked_inc.sv
// Masked-subset incrementer: steps the enumerated bits of a vector to the next subset of mask.
// Purely combinational (zero latency); no flow control.
// Ports: cur/mask in, next = ((cur | ~mask) + 1) & mask, wrap = (next == 0).
module masked_inc #(
    parameter int W = formula_sweep_pkg::NUM_IN_DEF
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] mask,
    output logic [W-1:0] next,
    output logic         wrap
);

    // Forcing unmasked bits to 1 lets the carry ripple straight across them,
    // so a plain add walks every subset of mask in increasing order.
    // The add is W bits wide, so the carry-out is dropped.
    logic [W-1:0] filled;
    logic [W-1:0] summed;

    always_comb begin
        filled = cur | ~mask;
        summed = filled + W'(1);
        next   = summed & mask;
        wrap   = (next == '0);
    end

endmodule

// File: rtl/formula_sweep_driver.sv
// Exhaustive sweep driver: enumerates all subsets of sweep_mask over fixed_val, checks f_in each cycle.
// Latency: one evaluation per clock in RUN; verdict appears the cycle after the last evaluation.
// Backpressure: verdict (res_*, fail_vec, eval_count) held in DONE until res_valid & res_ready.
// Ports: clk/rst_n; start/abort control; sweep_mask/fixed_val sampled at start; vec_out drives the
// formula, f_in is its same-cycle result; busy in RUN; res_valid/res_ready verdict handshake.
module formula_sweep_driver
    import formula_sweep_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int CNT_W  = NUM_IN + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_IN-1:0] sweep_mask,
    input  logic [NUM_IN-1:0] fixed_val,
    output logic [NUM_IN-1:0] vec_out,
    input  logic              f_in,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_fail,
    output logic              res_aborted,
    output logic [NUM_IN-1:0] fail_vec,
    output logic [CNT_W-1:0]  eval_count
);

    state_e            state_q;
    logic [NUM_IN-1:0] mask_q;
    logic [NUM_IN-1:0] fixed_q;
    logic [NUM_IN-1:0] vec_q;
    logic [NUM_IN-1:0] fail_vec_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fail_q;
    logic              aborted_q;

    // Next subset and the corresponding full vector.
    logic [NUM_IN-1:0] s_cur;
    logic [NUM_IN-1:0] s_d;
    logic [NUM_IN-1:0] vec_d;
    logic              wrap;

    assign s_cur = vec_q & mask_q;

    masked_inc #(
        .W (NUM_IN)
    ) u_inc (
        .cur  (s_cur),
        .mask (mask_q),
        .next (s_d),
        .wrap (wrap)
    );

    assign vec_d = s_d | (fixed_q & ~mask_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            fixed_q    <= '0;
            vec_q      <= '0;
            fail_vec_q <= '0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        mask_q    <= sweep_mask;
                        fixed_q   <= fixed_val;
                        vec_q     <= fixed_val & ~sweep_mask;
                        cnt_q     <= '0;
                        fail_q    <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // The f_in of this cycle is discarded and not counted.
                        state_q   <= ST_DONE;
                        aborted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!f_in) begin
                            state_q    <= ST_DONE;
                            fail_q     <= 1'b1;
                            fail_vec_q <= vec_q;
                        end else if (wrap) begin
                            // Current vector was the last subset; leave vec_out on it.
                            state_q <= ST_DONE;
                        end else begin
                            vec_q <= vec_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_out     = vec_q;
    assign busy        = (state_q == ST_RUN);
    assign res_valid   = (state_q == ST_DONE);
    assign res_fail    = fail_q;
    assign res_aborted = aborted_q;
    assign fail_vec    = fail_vec_q;
    assign eval_count  = cnt_q;

endmodule

// File: tb/tb_formula_sweep_driver.sv
module tb_formula_sweep_driver;

    localparam int N  = 25;
    localparam int CW = N + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  sweep_mask;
    logic [N-1:0]  fixed_val;
    logic [N-1:0]  vec_out;
    logic          f_in;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic          res_fail;
    logic          res_aborted;
    logic [N-1:0]  fail_vec;
    logic [CW-1:0] eval_count;

    // Formula under test: fails only on the target vector.
    logic [N-1:0]  tgt;
    assign f_in = (vec_out != tgt);

    int n_total;
    int n_pass;

    formula_sweep_driver #(.NUM_IN(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .sweep_mask  (sweep_mask),
        .fixed_val   (fixed_val),
        .vec_out     (vec_out),
        .f_in        (f_in),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_fail    (res_fail),
        .res_aborted (res_aborted),
        .fail_vec    (fail_vec),
        .eval_count  (eval_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  mask;
        logic [N-1:0]  fixed;
        logic [N-1:0]  tgt;
        logic          exp_fail;
        logic [N-1:0]  exp_fail_vec;
        logic [CW-1:0] exp_cnt;
        logic [N-1:0]  exp_last_vec;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_start(input logic [N-1:0] m, input logic [N-1:0] f);
        @(negedge clk);
        sweep_mask = m;
        fixed_val  = f;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        i = 0;
        while (!res_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_done_seen"}, 64'(res_valid), 64'd1);
    endtask

    task automatic accept(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({name, "_released"}, 64'(res_valid), 64'd0);
    endtask

    vec_t tbl [5];

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        sweep_mask = '0;
        fixed_val  = '0;
        tgt        = '0;

        // Scenario-style table: mask, fixed, failing target, expected verdict.
        tbl[0] = '{25'h0000003, 25'h1FFFFFF, 25'h0000000, 1'b0, 25'h0, 26'd4, 25'h1FFFFFF};
        tbl[1] = '{25'h00000F0, 25'h0000000, 25'h0000050, 1'b1, 25'h0000050, 26'd6, 25'h0000050};
        tbl[2] = '{25'h0000000, 25'h0ABCDEF, 25'h0ABCDEF, 1'b1, 25'h0ABCDEF, 26'd1, 25'h0ABCDEF};
        tbl[3] = '{25'h1000001, 25'h0FFFFFE, 25'h1FFFFFE, 1'b1, 25'h1FFFFFE, 26'd3, 25'h1FFFFFE};
        tbl[4] = '{25'h0000000, 25'h1234567, 25'h0000000, 1'b0, 25'h0, 26'd1, 25'h1234567};

        #12;
        chk("rst_vec_out", 64'(vec_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_eval_count", 64'(eval_count), 64'd0);
        rst_n = 1'b1;

        // abort while idle is ignored
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);
        chk("idle_abort_valid", 64'(res_valid), 64'd0);

        for (int k = 0; k < 5; k++) begin
            tgt = tbl[k].tgt;
            do_start(tbl[k].mask, tbl[k].fixed);
            wait_done(40, $sformatf("t%0d", k));
            chk($sformatf("t%0d_fail", k), 64'(res_fail), 64'(tbl[k].exp_fail));
            chk($sformatf("t%0d_aborted", k), 64'(res_aborted), 64'd0);
            chk($sformatf("t%0d_count", k), 64'(eval_count), 64'(tbl[k].exp_cnt));
            chk($sformatf("t%0d_vec_out", k), 64'(vec_out), 64'(tbl[k].exp_last_vec));
            if (tbl[k].exp_fail)
                chk($sformatf("t%0d_fail_vec", k), 64'(fail_vec), 64'(tbl[k].exp_fail_vec));
            accept($sformatf("t%0d", k));
        end

        // Exact vector sequence, one evaluation per cycle
        begin
            logic [N-1:0] seq [4];
            seq[0] = 25'h1FFFFFC; seq[1] = 25'h1FFFFFD;
            seq[2] = 25'h1FFFFFE; seq[3] = 25'h1FFFFFF;
            tgt = '0;
            do_start(25'h0000003, 25'h1FFFFFF);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("seq%0d_vec", i), 64'(vec_out), 64'(seq[i]));
                chk($sformatf("seq%0d_busy", i), 64'(busy), 64'd1);
                @(negedge clk);
            end
            chk("seq_valid", 64'(res_valid), 64'd1);
            chk("seq_count", 64'(eval_count), 64'd4);
            accept("seq");
        end

        // Abort on 10th RUN cycle with full mask, then backpressure
        begin
            logic [N-1:0]  hold_vec;
            tgt = 25'h1FFFFFF;
            do_start(25'h1FFFFFF, 25'h0000000);
            repeat (9) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("ab_valid", 64'(res_valid), 64'd1);
            chk("ab_aborted", 64'(res_aborted), 64'd1);
            chk("ab_fail", 64'(res_fail), 64'd0);
            chk("ab_count", 64'(eval_count), 64'd9);
            hold_vec = vec_out;
            chk("ab_vec", 64'(vec_out), 64'd9);
            for (int i = 0; i < 5; i++) begin
                if (i == 2) start = 1'b1;
                @(negedge clk);
                chk($sformatf("ab_hold%0d_valid", i), 64'(res_valid), 64'd1);
                chk($sformatf("ab_hold%0d_cnt", i), 64'(eval_count), 64'd9);
                chk($sformatf("ab_hold%0d_vec", i), 64'(vec_out), 64'(hold_vec));
                chk($sformatf("ab_hold%0d_abt", i), 64'(res_aborted), 64'd1);
                start = 1'b0;
            end
            // start during the handshake cycle must be ignored
            start     = 1'b1;
            res_ready = 1'b1;
            @(negedge clk);
            start     = 1'b0;
            res_ready = 1'b0;
            chk("ab_hs_valid", 64'(res_valid), 64'd0);
            @(negedge clk);
            chk("ab_hs_busy", 64'(busy), 64'd0);
        end

        // start pulses during RUN do not disturb the sweep
        tgt = 25'h0000050;
        do_start(25'h00000F0, 25'h0000000);
        @(negedge clk);
        sweep_mask = 25'h1FFFFFF;
        fixed_val  = 25'h1FFFFFF;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done(40, "sr");
        chk("sr_fail_vec", 64'(fail_vec), 64'h50);
        chk("sr_count", 64'(eval_count), 64'd6);
        chk("sr_fail", 64'(res_fail), 64'd1);
        accept("sr");

        // Reset in the middle of a sweep
        tgt = 25'h1FFFFFF;
        do_start(25'h1FFFFFF, 25'h0000000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_vec_out", 64'(vec_out), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_count", 64'(eval_count), 64'd0);
        chk("mr_fail", 64'(res_fail), 64'd0);
        chk("mr_aborted", 64'(res_aborted), 64'd0);
        chk("mr_fail_vec", 64'(fail_vec), 64'd0);
        chk("mr_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_no_verdict", 64'(res_valid), 64'd0);
        chk("mr_idle", 64'(busy), 64'd0);
        tgt = '0;
        do_start(25'h0000003, 25'h1FFFFFF);
        wait_done(40, "pr");
        chk("pr_count", 64'(eval_count), 64'd4);
        chk("pr_fail", 64'(res_fail), 64'd0);
        chk("pr_vec", 64'(vec_out), 64'h1FFFFFF);
        accept("pr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/formula_sweep_driver.md
FORMULA_SWEEP_DRIVER -- requirements
Module: formula_sweep_driver

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 25, giving the formula input vector width.
REQ-002 The block SHALL have parameter CNT_W, default NUM_IN+1, giving the evaluation counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle pulse that begins a sweep; it SHALL be ignored unless the state is IDLE.
REQ-006 The block SHALL have port abort, input, 1, which ends a running sweep.
REQ-007 The block SHALL have port sweep_mask, input, NUM_IN; a 1 marks an input bit as enumerated, and the value is sampled at start.
REQ-008 The block SHALL have port fixed_val, input, NUM_IN, giving the values for unmasked bits; it is sampled at start.
REQ-009 The block SHALL have port vec_out, output, NUM_IN, a registered vector that drives the combinational formula under test.
REQ-010 The block SHALL have port f_in, input, 1, the formula output for the current vec_out, returned in the same cycle.
REQ-011 The block SHALL have port busy, output, 1, high while in RUN.
REQ-012 The block SHALL have port res_valid, output, 1, the verdict-valid strobe.
REQ-013 The block SHALL have port res_ready, input, 1, the verdict acceptance from downstream.
REQ-014 The block SHALL have port res_fail, output, 1; it is 1 when a falsifying vector was found.
REQ-015 The block SHALL have port res_aborted, output, 1; it is 1 when the sweep was ended by abort.
REQ-016 The block SHALL have port fail_vec, output, NUM_IN, holding the first vector for which f_in=0.
REQ-017 The block SHALL have port eval_count, output, CNT_W, giving the number of vectors evaluated in this sweep.

Function
REQ-018 The block SHALL implement the states IDLE, RUN and DONE.
REQ-019 IDLE to RUN: on start, the block SHALL latch mask M and fixed value F, load vec_out = F & ~M, and clear eval_count, res_fail and res_aborted.
REQ-020 RUN: each cycle the block SHALL sample f_in against the current vec_out and increment eval_count, giving one evaluation per cycle.
REQ-021 The enumerated part of vec_out SHALL be the masked subset S, with next S = ((S | ~M) + 1) & M, computed NUM_IN bits wide with the carry-out discarded.
REQ-022 vec_out SHALL equal S | (F & ~M).
REQ-023 If f_in=0 in RUN, the block SHALL set fail_vec = vec_out and res_fail=1, and go to DONE that cycle; the first failure wins.
REQ-024 Wrap: when next S = 0, the current vector is the last one; after it is evaluated with f_in=1, the block SHALL go to DONE with res_fail=0.
REQ-025 M=0 SHALL give exactly one evaluation, eval_count=1.
REQ-026 M all-ones SHALL give 2^NUM_IN evaluations, and eval_count SHALL not overflow with CNT_W=NUM_IN+1.
REQ-027 abort in RUN SHALL take priority over the f_in sample that same cycle; the block SHALL go to DONE with res_aborted=1, and eval_count SHALL exclude that cycle.
REQ-028 abort outside RUN SHALL be ignored.
REQ-029 DONE: res_valid=1, and all res_* outputs, fail_vec and eval_count SHALL be held stable until res_valid & res_ready, then the block SHALL go to IDLE.
REQ-030 start asserted in DONE SHALL be ignored, including in the cycle of the handshake.
REQ-031 vec_out SHALL hold its last value in IDLE and DONE.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, vec_out=0, fail_vec=0, eval_count=0, busy=0, res_valid=0, res_fail=0 and res_aborted=0.
REQ-033 A reset in the middle of a sweep SHALL discard the sweep, and no verdict SHALL be produced.
REQ-034 The block SHALL leave reset synchronously on the first clk edge after rst_n rises.

Structure
REQ-035 The state enum and the default NUM_IN SHALL reside in the shared package formula_sweep_pkg.
REQ-036 The masked-subset incrementer SHALL be one combinational sub-module, masked_inc, with ports cur, mask, next and wrap.
REQ-037 The RTL SHALL be 120-400 lines, with no other sub-modules.

Verification
REQ-038 Scenario 1: NUM_IN=25, M=0x0000003, F=0x1FFFFFF, f_in tied to 1 -> vec_out = 0x1FFFFFC, 0x1FFFFFD, 0x1FFFFFE, 0x1FFFFFF, then res_valid with res_fail=0 and eval_count=4.
REQ-039 Scenario 2: M=0x00000F0, F=0, f_in = ~(vec_out==0x0000050) -> res_fail=1, fail_vec=0x0000050, eval_count=6.
REQ-040 Scenario 3: M=0, F=0x0ABCDEF, f_in=0 -> exactly 1 evaluation, fail_vec=0x0ABCDEF.
REQ-041 Scenario 4: M=0x1FFFFFF, abort on the 10th RUN cycle -> res_aborted=1, eval_count=9; res_ready held low 5 cycles -> outputs stable for those cycles.
REQ-042 Scenario 5: rst_n pulsed low in the middle of RUN -> all outputs 0 immediately; a following start sweeps normally.
REQ-043 Scenario 6: start asserted during RUN and during DONE -> no effect on vec_out, eval_count or the verdict.
